// File: rtl/console_tx_queue_pkg.sv
// Shared types and constants for the console transmit queue.
// Used by the output FSM and the LF -> CR LF expansion logic.
package console_tx_queue_pkg;

  typedef enum logic [1:0] {
    CQ_IDLE,
    CQ_SEND,
    CQ_SEND_CR
  } console_q_state_e;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/console_tx_queue_byte_fifo.sv
// Byte FIFO with a level counter; full/empty decode from the registered level.
// Zero-latency head read; push when full and pop when empty are ignored.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [7:0]               head_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level_q;
  logic          push_ok;
  logic          pop_ok;

  assign full      = (level_q == FULL_LVL);
  assign empty     = (level_q == '0);
  assign level     = level_q;
  assign head_data = mem[rd_ptr];
  assign push_ok   = push && !full && !flush;
  assign pop_ok    = pop && !empty && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/console_tx_queue.sv
// Console TX queue: MMIO byte writes -> FIFO -> registered AXI-stream stage with optional LF->CR LF.
// Two cycles write-to-tvalid when idle; overflowing writes are dropped and counted.
module console_tx_queue
  import console_tx_queue_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter bit CRLF   = 1'b1,
  parameter int DROP_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clk_en,
  input  logic [7:0]               i_wr_data,
  input  logic                     i_wr_en,
  input  logic                     i_flush,
  output logic [7:0]               m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_overflow,
  output logic [DROP_W-1:0]        o_drop_count
);

  console_q_state_e state_q, state_d;
  logic [7:0]       data_q, data_d;
  logic [7:0]       head_data;
  logic             fifo_full;
  logic             fifo_empty;
  logic             wr_req;
  logic             push;
  logic             drop;
  logic             pop;
  logic             stage_free;
  logic             overflow_q;
  logic [DROP_W-1:0] drop_q;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (i_wr_data),
    .pop       (pop),
    .flush     (i_flush),
    .head_data (head_data),
    .level     (o_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Fullness is judged on the start-of-cycle level: a same-cycle pop makes no room.
  assign wr_req     = i_wr_en && clk_en && !i_flush;
  assign push       = wr_req && !fifo_full;
  assign drop       = wr_req && fifo_full;
  assign stage_free = (state_q == CQ_IDLE) || ((state_q == CQ_SEND) && m_axis_tready);
  assign pop        = stage_free && !fifo_empty && !i_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CQ_IDLE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (i_flush) begin
      state_d = CQ_IDLE;
    end else if (state_q == CQ_SEND_CR) begin
      if (m_axis_tready) begin
        state_d = CQ_SEND;
        data_d  = ASCII_LF;
      end
    end else if (stage_free) begin
      if (!fifo_empty) begin
        data_d  = head_data;
        state_d = (CRLF && head_data == ASCII_LF) ? CQ_SEND_CR : CQ_SEND;
      end else begin
        state_d = CQ_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else if (i_flush) begin
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (drop_q != '1) drop_q <= drop_q + 1'b1;
    end
  end

  assign m_axis_tvalid = (state_q != CQ_IDLE);
  assign m_axis_tdata  = (state_q == CQ_SEND_CR) ? ASCII_CR : data_q;
  assign o_empty       = fifo_empty && (state_q == CQ_IDLE);
  assign o_full        = fifo_full;
  assign o_overflow    = overflow_q;
  assign o_drop_count  = drop_q;

endmodule
